// File: rtl/spwm_tri_cmp_if.sv
// Triangle-ROM port bundle: address/enable out of the modulator, synchronous-read data back in.
interface spwm_tri_cmp_if #(
    parameter int unsigned DW = 10
) ();
    logic [5:0]    rom_ad;
    logic          rom_ce;
    logic [DW-1:0] rom_dout;

    modport master (output rom_ad, output rom_ce, input rom_dout);
    modport slave  (input rom_ad, input rom_ce, output rom_dout);
endinterface

// File: rtl/spwm_tri_cmp.sv
// Sine-PWM modulator: steps a triangle carrier out of an external ROM, compares it against a
// per-period modulation sample and drives complementary gates with dead-time insertion.
module spwm_tri_cmp #(
    parameter int unsigned TBL_LEN = 50,
    parameter int unsigned DW      = 10,
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DT_W    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_W-1:0]     div_i,
    input  logic [DW-1:0]        mod_val_i,
    input  logic [DT_W-1:0]      dead_i,
    spwm_tri_cmp_if.master       rom,
    output logic [DW-1:0]        carrier_o,
    output logic                 period_start_o,
    output logic                 pwm_h_o,
    output logic                 pwm_l_o
);

    localparam logic [5:0] LastAd = 6'(TBL_LEN - 1);

    typedef enum logic [2:0] {StIdle, StHi, StDtHl, StLo, StDtLh} state_e;

    logic             run_q;
    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic [5:0]       ad_q, ad_d;
    logic             wrap_q, wrap_d;
    logic [DW-1:0]    mod_q, mod_d;
    logic [DW-1:0]    mod_s1_q, mod_s1_d;
    logic             v1_q, v2_q, v2_d;
    logic             cmp_q, cmp_d;
    logic [DW-1:0]    carrier_q, carrier_d;
    state_e           state_q, state_d;
    logic [DT_W-1:0]  dt_q, dt_d;
    logic             start, tick;

    // First enabled cycle presents address 0 from the cleared counter.
    assign start = en_i & ~run_q;
    assign tick  = en_i & (pcnt_q >= div_i);

    always_comb begin
        pcnt_d = pcnt_q;
        ad_d   = ad_q;
        wrap_d = 1'b0;
        mod_d  = mod_q;
        if (!en_i) begin
            pcnt_d = '0;
            ad_d   = '0;
            mod_d  = '0;
        end else begin
            if (start) begin
                mod_d = mod_val_i;
            end
            if (tick) begin
                pcnt_d = '0;
                if (ad_q >= LastAd) begin
                    ad_d   = '0;
                    wrap_d = 1'b1;
                    mod_d  = mod_val_i;
                end else begin
                    ad_d = ad_q + 6'd1;
                end
            end else begin
                pcnt_d = pcnt_q + DIV_W'(1);
            end
        end
    end

    // Each sample carries the modulation value of its own period down the pipe.
    always_comb begin
        mod_s1_d  = start ? mod_val_i : mod_q;
        v2_d      = en_i & v1_q;
        cmp_d     = v1_q & (rom.rom_dout < mod_s1_q);
        carrier_d = v1_q ? rom.rom_dout : carrier_q;
    end

    always_comb begin
        state_d = state_q;
        dt_d    = dt_q;
        if (!en_i) begin
            state_d = StIdle;
            dt_d    = '0;
        end else if (v2_q) begin
            unique case (state_q)
                StIdle: begin
                    state_d = cmp_q ? StDtLh : StDtHl;
                    dt_d    = dead_i;
                end
                StHi: begin
                    if (!cmp_q) begin
                        state_d = StDtHl;
                        dt_d    = dead_i;
                    end
                end
                StLo: begin
                    if (cmp_q) begin
                        state_d = StDtLh;
                        dt_d    = dead_i;
                    end
                end
                // A dead interval lasts max(dead, 1) clocks.
                StDtHl: begin
                    if (cmp_q)                     state_d = StHi;
                    else if (dt_q <= DT_W'(1))     state_d = StLo;
                    else                           dt_d    = dt_q - DT_W'(1);
                end
                StDtLh: begin
                    if (!cmp_q)                    state_d = StLo;
                    else if (dt_q <= DT_W'(1))     state_d = StHi;
                    else                           dt_d    = dt_q - DT_W'(1);
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q     <= 1'b0;
            pcnt_q    <= '0;
            ad_q      <= '0;
            wrap_q    <= 1'b0;
            mod_q     <= '0;
            mod_s1_q  <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            cmp_q     <= 1'b0;
            carrier_q <= '0;
            state_q   <= StIdle;
            dt_q      <= '0;
        end else begin
            run_q     <= en_i;
            pcnt_q    <= pcnt_d;
            ad_q      <= ad_d;
            wrap_q    <= wrap_d;
            mod_q     <= mod_d;
            mod_s1_q  <= mod_s1_d;
            v1_q      <= en_i;
            v2_q      <= v2_d;
            cmp_q     <= cmp_d;
            carrier_q <= carrier_d;
            state_q   <= state_d;
            dt_q      <= dt_d;
        end
    end

    assign rom.rom_ad     = ad_q;
    assign rom.rom_ce     = en_i;
    assign carrier_o      = carrier_q;
    assign period_start_o = en_i & ~rst_i & (start | wrap_q);
    assign pwm_h_o        = (state_q == StHi);
    assign pwm_l_o        = (state_q == StLo);

endmodule

// File: tb/tb_spwm_tri_cmp.sv
// Bench for spwm_tri_cmp: per-period gate statistics from a vector table, plus directed
// sequences for start-up, mid-period modulation changes, async reset and enable drop.
module tb_spwm_tri_cmp;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [15:0] div;
    logic [9:0] mod_val;
    logic [7:0] dead;
    logic [9:0] carrier;
    logic       period_start, pwm_h, pwm_l;

    spwm_tri_cmp_if #(.DW(10)) rif ();

    spwm_tri_cmp dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .div_i          (div),
        .mod_val_i      (mod_val),
        .dead_i         (dead),
        .rom            (rif),
        .carrier_o      (carrier),
        .period_start_o (period_start),
        .pwm_h_o        (pwm_h),
        .pwm_l_o        (pwm_l)
    );

    always #5 clk = ~clk;

    // Triangle: 0 at address 0, 1023 at 25, back down toward 0 at 49.
    function automatic logic [9:0] tri_val(input logic [5:0] a);
        int x;
        x = (a <= 6'd25) ? int'(a) : 50 - int'(a);
        return 10'(x * 1023 / 25);
    endfunction

    always @(posedge clk) if (rif.rom_ce) rif.rom_dout <= tri_val(rif.rom_ad);

    typedef struct {
        int div; int dead; int mod; int period; int h; int l; int run;
    } vec_t;

    vec_t vecs[6];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ps(input string name);
        int c;
        for (c = 0; c < 300 && !period_start; c++) @(negedge clk);
        if (!period_start) chk({name, " timeout"}, 0, 1);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int ps, h, l, ovl, maxad, run, maxrun, len;
        bit win;
        v = vecs[idx];
        do_reset();
        div     = 16'(v.div);
        dead    = 8'(v.dead);
        mod_val = 10'(v.mod);
        en      = 1'b1;
        ps = 0; h = 0; l = 0; ovl = 0; maxad = 0; run = 0; maxrun = 0; len = 0; win = 1'b0;
        for (int c = 0; c < 2000 && ps < 6; c++) begin
            @(negedge clk);
            if (int'(rif.rom_ad) > maxad) maxad = int'(rif.rom_ad);
            if (period_start) begin
                ps++;
                win = (ps == 5);
            end
            if (win) begin
                len++;
                h   += int'(pwm_h);
                l   += int'(pwm_l);
                ovl += int'(pwm_h & pwm_l);
                if (!pwm_h && !pwm_l) run++;
                else begin
                    if (run > maxrun) maxrun = run;
                    run = 0;
                end
            end
        end
        chk($sformatf("v%0d period_starts", idx), ps, 6);
        chk($sformatf("v%0d period_len", idx), len, v.period);
        chk($sformatf("v%0d pwm_h_clks", idx), h, v.h);
        chk($sformatf("v%0d pwm_l_clks", idx), l, v.l);
        chk($sformatf("v%0d overlap", idx), ovl, 0);
        chk($sformatf("v%0d dead_run", idx), maxrun, v.run);
        chk($sformatf("v%0d max_rom_ad", idx), maxad, 49);
    endtask

    initial begin
        int cnt;
        //            div dead mod  period  h    l  run
        vecs[0] = '{0, 0, 512,  50,  24,  24, 1};
        vecs[1] = '{0, 3, 512,  50,  22,  22, 3};
        vecs[2] = '{1, 0, 512, 100,  49,  49, 1};
        vecs[3] = '{0, 2,   0,  50,   0,  50, 0};
        vecs[4] = '{0, 0, 1023, 50,  49,   0, 1};
        vecs[5] = '{2, 5, 300, 150,  40, 100, 5};

        // Reset state, with en already high to cover the gated start pulse.
        rst = 1'b1; en = 1'b1; div = '0; dead = '0; mod_val = 10'd512;
        #12;
        chk("rst rom_ad", int'(rif.rom_ad), 0);
        chk("rst period_start", int'(period_start), 0);
        chk("rst pwm_h", int'(pwm_h), 0);
        chk("rst pwm_l", int'(pwm_l), 0);
        chk("rst carrier", int'(carrier), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("start rom_ad", int'(rif.rom_ad), 0);
        chk("start period_start", int'(period_start), 1);
        @(negedge clk);
        chk("step rom_ad", int'(rif.rom_ad), 1);
        chk("step period_start", int'(period_start), 0);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Mid-period modulation change must wait for the next period.
        do_reset();
        div = '0; dead = 8'd2; mod_val = 10'd0; en = 1'b1;
        @(negedge clk);
        wait_ps("mod ps1");
        @(negedge clk);
        repeat (20) @(negedge clk);
        mod_val = 10'd1023;
        cnt = 0;
        for (int c = 0; c < 100 && !period_start; c++) begin
            @(negedge clk);
            cnt += int'(pwm_h);
        end
        chk("mod hold pwm_h", cnt, 0);
        chk("mod hold ps seen", int'(period_start), 1);
        repeat (2) @(negedge clk);
        chk("mod w+2 pwm_l", int'(pwm_l), 1);
        @(negedge clk);
        chk("mod w+3 pwm_l", int'(pwm_l), 0);
        @(negedge clk);
        chk("mod w+4 pwm_h", int'(pwm_h), 0);
        @(negedge clk);
        chk("mod w+5 pwm_h", int'(pwm_h), 1);

        // Asynchronous reset while the high side is on.
        rst = 1'b1;
        #1;
        chk("async rst pwm_h", int'(pwm_h), 0);
        chk("async rst pwm_l", int'(pwm_l), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rerun rom_ad", int'(rif.rom_ad), 0);
        chk("rerun period_start", int'(period_start), 1);

        // Enable drop and restart with a fresh modulation value.
        repeat (30) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en0 pwm_h", int'(pwm_h), 0);
        chk("en0 pwm_l", int'(pwm_l), 0);
        chk("en0 period_start", int'(period_start), 0);
        chk("en0 rom_ad", int'(rif.rom_ad), 0);
        mod_val = 10'd0;
        en = 1'b1;
        #1;
        chk("en1 period_start", int'(period_start), 1);
        chk("en1 rom_ad", int'(rif.rom_ad), 0);
        repeat (4) @(negedge clk);
        chk("en1 s+4 pwm_l", int'(pwm_l), 0);
        @(negedge clk);
        chk("en1 s+5 pwm_l", int'(pwm_l), 1);
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            cnt += int'(pwm_h);
        end
        chk("en1 pwm_h quiet", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spwm_tri_cmp.md
SPWM_TRI_CMP -- requirements
Module: spwm_tri_cmp

Interface
REQ-001 Parameter TBL_LEN, default 50: number of valid triangle-table addresses per carrier period (0..TBL_LEN-1); addresses above are never issued.
REQ-002 Parameter DW, default 10: carrier/modulation sample width.
REQ-003 Parameter DIV_W, default 16: prescaler width.
REQ-004 Parameter DT_W, default 8: dead-time counter width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 en  in  1  run enable.
REQ-008 div  in  DIV_W  clocks per table step minus 1.
REQ-009 mod_val  in  DW  modulation sample (sine value, unsigned).
REQ-010 dead  in  DT_W  dead-time length in clocks.
REQ-011 rom_ad  out  6  triangle ROM address.
REQ-012 rom_ce  out  1  ROM clock enable.
REQ-013 rom_dout  in  DW  ROM data, valid one clk after rom_ad/rom_ce (sync-read ROM, output register bypassed).
REQ-014 carrier  out  DW  registered copy of current carrier sample.
REQ-015 period_start  out  1  one-clk pulse when rom_ad is set to 0 at the start of a period.
REQ-016 pwm_h  out  1  high-side gate.
REQ-017 pwm_l  out  1  low-side gate.

Function
REQ-018 Prescaler pcnt SHALL count 0..div while en=1; tick asserted in the cycle pcnt==div, pcnt then returns to 0; div=0 gives a tick every clk.
REQ-019 On tick, rom_ad SHALL increment; at TBL_LEN-1 it SHALL wrap to 0 and pulse period_start in the cycle rom_ad becomes 0.
REQ-020 div changes SHALL take effect at the next pcnt compare; if pcnt>div after a change, pcnt SHALL wrap to 0 next clk with a tick.
REQ-021 rom_ce SHALL equal en.
REQ-022 mod_q (internal) SHALL latch mod_val on the same edge that sets rom_ad to 0; mod_val changes mid-period SHALL NOT affect outputs until the next period.
REQ-023 Pipeline: rom_ad at cycle t -> rom_dout at t+1 -> carrier and cmp=(rom_dout<mod_q) registered at t+2 -> pwm_h/pwm_l registered at t+3; cmp SHALL use the mod_q belonging to the sample's period.
REQ-024 Arithmetic unsigned; mod_q=0 gives cmp=0 always; mod_q=1023 gives cmp=0 only at carrier 1023.
REQ-025 Gate FSM states: IDLE, HI, DT_HL, LO, DT_LH; pwm_h=1 only in HI, pwm_l=1 only in LO, both 0 elsewhere; pwm_h and pwm_l SHALL never be 1 together.
REQ-026 IDLE -> DT_LH if cmp=1 else DT_HL on first valid cmp after enable.
REQ-027 HI with cmp=0 -> DT_HL, dead counter loaded with dead; LO with cmp=1 -> DT_LH.
REQ-028 DT_HL: after dead clocks with both gates low -> LO; if cmp returns to 1 before expiry -> HI directly. DT_LH symmetric (expiry -> HI, cmp=0 -> LO).
REQ-029 dead=0: dead states SHALL last exactly one clk (both low one clk) -- no direct HI<->LO transition.
REQ-030 dead is sampled on dead-state entry; changes during a dead interval SHALL NOT alter it.
REQ-031 en=0 (synchronous): pcnt, rom_ad, mod_q, pipeline valids cleared, FSM -> IDLE, pwm_h=pwm_l=0 next clk, period_start=0.
REQ-032 en 0->1: first cycle with en=1 issues rom_ad=0 with period_start=1 and latches mod_q.

Reset
REQ-033 reset=1 SHALL asynchronously force: pcnt=0, rom_ad=0, mod_q=0, carrier=0, period_start=0, pwm_h=0, pwm_l=0, FSM=IDLE, dead counter=0, pipeline valids=0.
REQ-034 After reset release with en=1, behaviour SHALL be identical to REQ-032.
REQ-035 Reset asserted mid-dead-time or mid-HI SHALL drop both gates in the same cycle without waiting for a clk.

Verification
REQ-036 div=0, dead=0, mod_val=512: period 50 clks; pwm_h high for carrier at addresses 0..12 and 38..49 (25 samples), pwm_l for 13..37 minus dead clks; period_start every 50 clks.
REQ-037 div=1: rom_ad changes every 2 clks, period_start every 100 clks, rom_ad never exceeds 49.
REQ-038 dead=3, mod_val=512: each gate transition shows exactly 3 clks of pwm_h=pwm_l=0; never both high.
REQ-039 mod_val=0: pwm_h never asserts; pwm_l steady high after initial dead interval; mod_val changed to 1023 mid-period -> no effect until next period_start.
REQ-040 Reset pulsed while pwm_h=1: pwm_h falls asynchronously; after release rom_ad=0 with period_start=1 on first en=1 clk.
REQ-041 en dropped mid-period then reasserted: gates low next clk; restart at rom_ad=0 with fresh mod_q.
